fnd_scan_ctrl: RTL and testbench
================================

Name: fnd_scan_ctrl

Overview:
- Downstream display stage for counter_100. It consumes the binary count and run flag and drives a 4-digit, common-anode, time-multiplexed 7-segment (FND) display.
- A sequential double-dabble converter turns the count into BCD. A scan divider rotates the digit enables.
- The displayed value is sampled only at frame boundaries, so no tearing can occur.

Parameters:
- CNT_W, 7, width of i_cnt. Legal range is 1..13, so the maximum input of 8191 fits in 4 BCD digits.
- SCAN_DIV, 100000, clocks per digit slot. Must be ≥ CNT_W+2 so a conversion completes inside one slot.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_cnt  input  CNT_W  binary value to display (counter_100 o_cnt).
- i_run  input  1  run indicator; lights the digit-0 decimal point.
- o_fnd_com  output  4  digit enables, active-low; bit n = digit n, digit 0 = units.
- o_fnd_data  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- o_digit_tick  output  1  one-cycle pulse when the digit index advances.

Behaviour:
- Single clock domain. reset is asynchronous, active-high and clears every register immediately.
- Reset state:
  - div = 0, idx = 0.
  - FSM = IDLE.
  - Display BCD regs = 0000; display dp = 0.
  - o_fnd_com = 4'b1110, o_fnd_data = 8'hC0 (digit 0 shows "0"), o_digit_tick = 0.
- Scan divider:
  - div counts 0..SCAN_DIV-1, then wraps to 0.
  - When div == SCAN_DIV-1: o_digit_tick = 1 that cycle, and idx advances mod 4 on the same edge.
  - o_fnd_com = ~(4'b0001 << idx), combinational from registered idx.
- Frame boundary:
  - Defined as a tick with idx == 3, i.e. idx wraps to 0.
  - On that edge: i_cnt is captured into the shift register, i_run is captured into pend_dp, and the FSM goes IDLE→CONV.
  - No other edge samples i_cnt or i_run.
- FSM:
  - IDLE: wait for a frame boundary.
  - CONV: runs exactly CNT_W cycles. Each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. A bit counter tracks progress; after CNT_W shifts, go to DONE.
  - DONE: one cycle. Copy the BCD result into the display regs and pend_dp into display dp, then go to IDLE.
  - Latency from the frame-boundary edge to new display data is CNT_W+1 cycles. This always lands within slot 0.
- Frame boundary while not IDLE: cannot occur given the SCAN_DIV constraint. If it does, ignore it (no restart).
- Segment decode (before dp and blanking):
  - 0 → C0, 1 → F9, 2 → A4, 3 → B0, 4 → 99
  - 5 → 92, 6 → 82, 7 → F8, 8 → 80, 9 → 90
- Leading-zero blanking:
  - Digit n (n ≥ 1) shows 8'hFF if it and all higher digits are zero.
  - Digit 0 is never blanked.
  - Zeros below the most-significant non-zero digit are always shown.
- Decimal point: on digit 0 only, when display dp = 1, o_fnd_data bit 7 is forced to 0.
- o_fnd_data is a combinational decode of idx and the display regs, so it is aligned with o_fnd_com.
- Input changes between frame boundaries have no visible effect until the next boundary plus CNT_W+1 cycles.
- Reset mid-conversion: the conversion is abandoned and the display returns to "0" immediately. The first new sample is taken at the first frame boundary after deassert, 4·SCAN_DIV cycles later.

Test Plan (SCAN_DIV=4, CNT_W=7):
1. Reset held 3 cycles, then released, i_cnt=0 → during reset, com=1110 and data=C0. After release, com steps 1110→1101→1011→0111→1110 every 4 cycles, with one o_digit_tick per step; data=C0 on digit 0 and FF on digits 1–3.
2. i_cnt=42, i_run=0, then wait one frame boundary + 8 cycles → digit0=A4, digit1=99, digit2=FF, digit3=FF.
3. i_cnt=7, i_run=1 → digit0=78 (F8 with dp), digits 1–3=FF.
4. i_cnt=100 → digit0=C0, digit1=C0, digit2=F9, digit3=FF (internal zeros not blanked).
5. i_cnt=5 displayed; change to 9 six cycles after a frame boundary → digit0 stays 92 for the rest of that frame. It becomes 90 exactly 8 cycles after the next boundary edge.
6. i_cnt=99: assert reset 3 cycles into CONV → outputs immediately return to com=1110, data=C0. After release, 99 (digit0=90, digit1=90) appears only after the next frame boundary + 8 cycles.

Source files
------------

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl
//   Display stage for counter_100. The binary count is converted to four BCD
//   digits by a sequential double-dabble converter. The digits are then shown on
//   a 4-digit, common-anode, time-multiplexed 7-segment display.
//
//   The display registers are refreshed only at frame boundaries, so a frame
//   never shows a mix of old and new digits.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   i_cnt        binary value to display (CNT_W bits, 0..8191 max)
//   i_run        run indicator, lights the digit-0 decimal point
//   o_fnd_com    digit enables, active-low, bit n = digit n (digit 0 = units)
//   o_fnd_data   segments, active-low, {dp,g,f,e,d,c,b,a}
//   o_digit_tick one-cycle pulse on the cycle the digit index advances
module fnd_scan_ctrl #(
    parameter int CNT_W    = 7,
    parameter int SCAN_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_run,
    output logic [3:0]       o_fnd_com,
    output logic [7:0]       o_fnd_data,
    output logic             o_digit_tick
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BC_W  = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam int SR_W  = 16 + CNT_W;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(CNT_W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic             tick;
    logic             frame;

    logic [1:0]       state;
    logic [BC_W-1:0]  bit_cnt;
    logic [SR_W-1:0]  sr;        // {bcd[15:0], bin[CNT_W-1:0]}
    logic             pend_dp;
    logic [15:0]      disp_bcd;
    logic             disp_dp;

    logic [3:0]       dig;
    logic             blank;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift,
    // so that the shift carries correctly into the next decimal digit.
    function automatic logic [15:0] dd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign tick  = (div == DIV_LAST);
    // The last tick of digit 3 wraps idx to 0: this is the start of a new frame.
    assign frame = tick && (idx == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Conversion takes CNT_W shift cycles plus one copy cycle. With
    // SCAN_DIV >= CNT_W+2 it always completes inside slot 0. A boundary that
    // arrives while a conversion is still busy is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            sr       <= '0;
            pend_dp  <= 1'b0;
            disp_bcd <= 16'd0;
            disp_dp  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame) begin
                        sr      <= {16'd0, i_cnt};
                        pend_dp <= i_run;
                        bit_cnt <= '0;
                        state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    sr <= {dd_adjust(sr[SR_W-1:CNT_W]), sr[CNT_W-1:0]} << 1;
                    if (bit_cnt == BC_LAST)
                        state <= ST_DONE;
                    else
                        bit_cnt <= bit_cnt + 1'b1;
                end
                ST_DONE: begin
                    disp_bcd <= sr[SR_W-1:CNT_W];
                    disp_dp  <= pend_dp;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_fnd_com    = ~(4'b0001 << idx);
    assign o_digit_tick = tick;

    // A digit above the units is blanked when it and every higher digit are
    // zero. Zeros below the leading digit therefore stay visible.
    always_comb begin
        dig   = disp_bcd[3:0];
        blank = 1'b0;
        case (idx)
            2'd0: begin
                dig   = disp_bcd[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                dig   = disp_bcd[7:4];
                blank = (disp_bcd[15:4] == 12'd0);
            end
            2'd2: begin
                dig   = disp_bcd[11:8];
                blank = (disp_bcd[15:8] == 8'd0);
            end
            default: begin
                dig   = disp_bcd[15:12];
                blank = (disp_bcd[15:12] == 4'd0);
            end
        endcase
        o_fnd_data = blank ? 8'hFF : seg7(dig);
        if ((idx == 2'd0) && disp_dp)
            o_fnd_data[7] = 1'b0;
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Testbench for fnd_scan_ctrl with SCAN_DIV=4 and CNT_W=7.
//
// A reference model tracks the edges since reset, the frame boundaries and the
// value currently on display. It derives the expected enables, segments and
// tick from those using decimal arithmetic. Table vectors, random values and
// hand sequences exercise the multi-cycle corner cases.
module tb_fnd_scan_ctrl;

    localparam int CNT_W    = 7;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int LAT      = CNT_W + 1;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] i_cnt;
    logic             i_run;
    logic [3:0]       o_fnd_com;
    logic [7:0]       o_fnd_data;
    logic             o_digit_tick;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             run;
        logic [3:0][7:0]  dig;
    } vec_t;

    vec_t vecs [4];

    fnd_scan_ctrl #(.CNT_W(CNT_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_cnt        (i_cnt),
        .i_run        (i_run),
        .o_fnd_com    (o_fnd_com),
        .o_fnd_data   (o_fnd_data),
        .o_digit_tick (o_digit_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: edge count since reset, the shown value and the
    // sample that is waiting to become visible.
    int m_n        = 0;
    int m_val      = 0;
    bit m_dp       = 1'b0;
    int m_pend_val = 0;
    bit m_pend_dp  = 1'b0;
    int m_pend_cnt = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n        <= 0;
            m_val      <= 0;
            m_dp       <= 1'b0;
            m_pend_val <= 0;
            m_pend_dp  <= 1'b0;
            m_pend_cnt <= 0;
        end else begin
            m_n <= m_n + 1;
            if (m_pend_cnt == 1) begin
                m_val <= m_pend_val;
                m_dp  <= m_pend_dp;
            end
            if (m_pend_cnt > 0)
                m_pend_cnt <= m_pend_cnt - 1;
            if ((m_n + 1) % FRAME == 0) begin
                m_pend_val <= int'(i_cnt);
                m_pend_dp  <= i_run;
                m_pend_cnt <= LAT;
            end
        end
    end

    function automatic logic [7:0] exp_data(input int v, input bit dp, input int d);
        int p;
        logic [7:0] s;
        p = (d == 0) ? 1 : (d == 1) ? 10 : (d == 2) ? 100 : 1000;
        if (d > 0 && v < p)
            s = 8'hFF;
        else
            s = seg_lut[(v / p) % 10];
        if (d == 0 && dp)
            s[7] = 1'b0;
        return s;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        check_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Advance one clock and compare every output against the model.
    task automatic step();
        int idx;
        logic [3:0] ec;
        @(negedge clk);
        idx = (m_n / SCAN_DIV) % 4;
        ec = 4'b1111;
        ec[idx] = 1'b0;
        chk("com", {4'h0, o_fnd_com}, {4'h0, ec});
        chk("data", o_fnd_data, exp_data(m_val, m_dp, idx));
        chk("tick", {7'd0, o_digit_tick}, {7'd0, (m_n % SCAN_DIV) == SCAN_DIV - 1});
    endtask

    task automatic wait_boundary();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(m_n % FRAME == 0 && m_n > 0) && k < 3 * FRAME);
        if (!(m_n % FRAME == 0 && m_n > 0)) begin
            check_cnt++;
            $display("FAIL boundary_wait: got n=%0d, expected frame boundary", m_n);
        end
    endtask

    task automatic apply(input logic [CNT_W-1:0] v, input logic r);
        i_cnt = v;
        i_run = r;
        wait_boundary();
        repeat (LAT) step();
    endtask

    task automatic capture(input string name, input logic [3:0][7:0] expd);
        int idx;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (m_n % SCAN_DIV == 0) begin
                idx = (m_n / SCAN_DIV) % 4;
                chk($sformatf("%s_dig%0d", name, idx), o_fnd_data, expd[idx]);
            end
        end
    endtask

    initial begin
        int tc;
        logic [CNT_W-1:0] rv;
        logic rr;
        logic [3:0][7:0] rexp;

        vecs[0].cnt = 7'd42;  vecs[0].run = 1'b0; vecs[0].dig = {8'hFF, 8'hFF, 8'h99, 8'hA4};
        vecs[1].cnt = 7'd7;   vecs[1].run = 1'b1; vecs[1].dig = {8'hFF, 8'hFF, 8'hFF, 8'h78};
        vecs[2].cnt = 7'd100; vecs[2].run = 1'b0; vecs[2].dig = {8'hFF, 8'hF9, 8'hC0, 8'hC0};
        vecs[3].cnt = 7'd5;   vecs[3].run = 1'b0; vecs[3].dig = {8'hFF, 8'hFF, 8'hFF, 8'h92};

        // Reset held for three cycles, then a full frame of scanning.
        reset = 1'b1;
        i_cnt = '0;
        i_run = 1'b0;
        step();
        chk("rst_com", {4'h0, o_fnd_com}, 8'h0E);
        chk("rst_data", o_fnd_data, 8'hC0);
        chk("rst_tick", {7'd0, o_digit_tick}, 8'h00);
        step();
        step();
        reset = 1'b0;
        tc = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (o_digit_tick) tc++;
        end
        chk("tick_count", 8'(tc), 8'(4));

        for (int i = 0; i < 4; i++) begin
            apply(vecs[i].cnt, vecs[i].run);
            capture($sformatf("vec%0d", i), vecs[i].dig);
        end

        // 5 is on display; a change six cycles into a frame must not show in
        // that frame. It appears in the frame after the next boundary.
        wait_boundary();
        repeat (6) step();
        i_cnt = 7'd9;
        wait_boundary();
        chk("late_change_old", o_fnd_data, 8'h92);
        repeat (FRAME) step();
        chk("late_change_new", o_fnd_data, 8'h90);

        // Reset three cycles into a conversion of 99.
        i_cnt = 7'd99;
        wait_boundary();
        repeat (3) step();
        reset = 1'b1;
        #1;
        chk("midconv_rst_com", {4'h0, o_fnd_com}, 8'h0E);
        chk("midconv_rst_data", o_fnd_data, 8'hC0);
        repeat (3) step();
        reset = 1'b0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            step();
            if (m_n == SCAN_DIV)         chk("post_rst_dig1_blank", o_fnd_data, 8'hFF);
            if (m_n == FRAME)            chk("post_rst_dig0_old", o_fnd_data, 8'hC0);
            if (m_n == 2 * FRAME)        chk("post_rst_dig0_new", o_fnd_data, 8'h90);
            if (m_n == 2 * FRAME + SCAN_DIV) chk("post_rst_dig1_new", o_fnd_data, 8'h90);
        end

        // Random values checked against decimal arithmetic.
        for (int i = 0; i < 6; i++) begin
            rv = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
            rr = 1'($urandom_range(0, 1));
            for (int d = 0; d < 4; d++)
                rexp[d] = exp_data(int'(rv), rr, d);
            apply(rv, rr);
            capture($sformatf("rand%0d_v%0d", i, rv), rexp);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
